full_subtractor: RTL and testbench
==================================

Name: full_subtractor

Overview:
- 1-bit full subtractor computing a − b − bin, producing a difference bit and a borrow-out (port name spelled `barrow`).
- Provides a pure combinational path plus a registered copy with valid flag.
- Also provides a bit-serial mode that chains the borrow across cycles for LSB-first multi-bit subtraction.
- Used as a leaf arithmetic cell in datapaths and serial ALUs.

Parameters:
- CNT_W, default 8: width of the borrow-event counter (only present with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  minuend bit.
- b  input  1  subtrahend bit.
- bin  input  1  borrow-in.
- diff  output  1  combinational difference.
- barrow  output  1  combinational borrow-out.
- in_valid  input  1  capture a/b/bin result into registers this cycle.
- diff_q  output  1  registered diff.
- barrow_q  output  1  registered barrow.
- out_valid  output  1  registered in_valid.
- ser_en  input  1  serial step enable.
- ser_start  input  1  first bit of a serial word; forces borrow-in 0.
- ser_a  input  1  serial minuend bit, LSB first.
- ser_b  input  1  serial subtrahend bit, LSB first.
- ser_diff  output  1  registered serial difference bit.
- ser_borrow  output  1  current stored serial borrow (final borrow of the word after the last step).
- ser_valid  output  1  ser_diff updated in the previous cycle.
- borrow_cnt  output  CNT_W  borrow-out event count (optional feature only).

Behaviour:
- Combinational path (no clock dependency, zero latency):
  - diff = a XOR b XOR bin.
  - barrow = (~a & b) | (~a & bin) | (b & bin).
- Full truth table, {a,b,bin} → {diff,barrow}: 000→00, 001→11, 010→11, 011→01, 100→10, 101→00, 110→00, 111→11.
- The combinational outputs are valid during and after reset; they are unaffected by rst.
- Registered path, 1-cycle latency:
  - On a clk edge with in_valid=1: diff_q and barrow_q load the combinational values.
  - With in_valid=0: diff_q and barrow_q hold.
  - out_valid equals in_valid delayed by one cycle.
- Serial path:
  - Internal borrow register brw.
  - Borrow-in for a step is 0 if ser_start=1, else brw.
  - On an edge with ser_en=1: ser_diff ← ser_a ^ ser_b ^ bin_s, and brw ← full-subtract borrow of (ser_a, ser_b, bin_s).
  - ser_borrow = brw. ser_valid ← ser_en.
  - With ser_en=0: ser_diff and brw hold; ser_start is ignored.
  - ser_start with ser_en=1 mid-word abandons the old word and starts a new one.
- Reset (async, rst=1): diff_q, barrow_q, out_valid, ser_diff, brw, ser_valid and borrow_cnt all become 0 immediately and stay 0 while rst is high. A reset mid-serial-word discards that word.
- The registered and serial paths are independent and may be active in the same cycle.

Optional Feature:
- Macro FULL_SUB_STATS_EN.
- Defined:
  - borrow_cnt is present.
  - Increments by 1 on each edge where in_valid=1 and barrow=1.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - Cleared by rst.
- Undefined: the borrow_cnt port and counter logic are absent.

Test Plan:
- Exhaustive combinational: apply {a,b,bin}=0..7 at 10-unit intervals → diff/barrow match the truth table (e.g. 001→diff=1,barrow=1; 100→1,0; 111→1,1).
- Registered: a=0,b=1,bin=1 with in_valid=1 for one cycle → next cycle diff_q=0, barrow_q=1, out_valid=1; following cycle out_valid=0 and diff_q/barrow_q held.
- Serial: 4-bit 0101 − 0011, LSB first, ser_start on the first step, ser_en for 4 cycles → ser_diff bits 0,1,0,0 (result 0010), final ser_borrow=0. Then 0011 − 0101 → result 1110, ser_borrow=1.
- Async reset: assert rst between clock edges with diff_q=1 and brw=1 → both read 0 before the next edge; combinational diff/barrow still track the inputs.
- Restart: assert ser_start mid-word → that step uses borrow-in 0 regardless of brw.
- FULL_SUB_STATS_EN: CNT_W=2, seven in_valid cycles with barrow=1 → borrow_cnt saturates at 3.

Source files
------------

// File: rtl/full_subtractor.sv
// 1-bit full subtractor (a - b - bin) with combinational, registered and LSB-first
// bit-serial paths. Define FULL_SUB_STATS_EN to add the saturating borrow_cnt output.
module full_subtractor
`ifdef FULL_SUB_STATS_EN
  #(parameter int CNT_W = 8)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic barrow,
  input  logic in_valid,
  output logic diff_q,
  output logic barrow_q,
  output logic out_valid,
  input  logic ser_en,
  input  logic ser_start,
  input  logic ser_a,
  input  logic ser_b,
  output logic ser_diff,
  output logic ser_borrow,
  output logic ser_valid
`ifdef FULL_SUB_STATS_EN
  ,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);

  function automatic logic sub_borrow(input logic x, input logic y, input logic z);
    return (~x & y) | (~x & z) | (y & z);
  endfunction

  logic diff_d, barrow_d, out_valid_d, out_valid_q;
  logic ser_diff_d, ser_diff_q, brw_d, brw_q, ser_valid_d, ser_valid_q;
  logic bin_s;

  // Zero-latency path; deliberately independent of clk and rst.
  always_comb begin
    diff   = a ^ b ^ bin;
    barrow = sub_borrow(a, b, bin);
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    diff_d      = diff_q;
    barrow_d    = barrow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      diff_d   = diff;
      barrow_d = barrow;
    end

    // A new word (or a mid-word restart) never inherits the stored borrow.
    bin_s       = ser_start ? 1'b0 : brw_q;
    ser_diff_d  = ser_diff_q;
    brw_d       = brw_q;
    ser_valid_d = ser_en;
    if (ser_en) begin
      ser_diff_d = ser_a ^ ser_b ^ bin_s;
      brw_d      = sub_borrow(ser_a, ser_b, bin_s);
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q      <= 1'b0;
      barrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
      ser_diff_q  <= 1'b0;
      brw_q       <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      diff_q      <= diff_d;
      barrow_q    <= barrow_d;
      out_valid_q <= out_valid_d;
      ser_diff_q  <= ser_diff_d;
      brw_q       <= brw_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ser_diff   = ser_diff_q;
  assign ser_borrow = brw_q;
  assign ser_valid  = ser_valid_q;

`ifdef FULL_SUB_STATS_EN
  logic [CNT_W-1:0] borrow_cnt_d, borrow_cnt_q;

  // Saturating count of captured borrow-out events.
  always_comb begin
    borrow_cnt_d = borrow_cnt_q;
    if (in_valid && barrow && (borrow_cnt_q != {CNT_W{1'b1}}))
      borrow_cnt_d = borrow_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) borrow_cnt_q <= '0;
    else     borrow_cnt_q <= borrow_cnt_d;
  end

  assign borrow_cnt = borrow_cnt_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: directed cases plus randomized stimulus
// against an arithmetic reference model (serial words tracked as integer prefixes).
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst;
  logic a, b, bin, diff, barrow, in_valid, diff_q, barrow_q, out_valid;
  logic ser_en, ser_start, ser_a, ser_b, ser_diff, ser_borrow, ser_valid;
`ifdef FULL_SUB_STATS_EN
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  logic [CNT_W-1:0] borrow_cnt;
  int exp_cnt;
`endif

  always #5 clk = ~clk;

`ifdef FULL_SUB_STATS_EN
  full_subtractor #(.CNT_W(CNT_W)) dut (
`else
  full_subtractor dut (
`endif
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .diff(diff), .barrow(barrow),
    .in_valid(in_valid), .diff_q(diff_q), .barrow_q(barrow_q), .out_valid(out_valid),
    .ser_en(ser_en), .ser_start(ser_start), .ser_a(ser_a), .ser_b(ser_b),
    .ser_diff(ser_diff), .ser_borrow(ser_borrow), .ser_valid(ser_valid)
`ifdef FULL_SUB_STATS_EN
    , .borrow_cnt(borrow_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic exp_dq, exp_bq, exp_ov, exp_sd, exp_sb, exp_sv;
  int   wa, wb, wk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // a - b - bin as plain integer arithmetic: low bit is diff, negative means borrow.
  task automatic ref_sub(input logic x, input logic y, input logic z,
                         output logic d, output logic bo);
    int r;
    r  = int'(x) - int'(y) - int'(z);
    d  = r[0];
    bo = (r < 0);
  endtask

  task automatic model_clear();
    exp_dq = 0; exp_bq = 0; exp_ov = 0; exp_sd = 0; exp_sb = 0; exp_sv = 0;
    wa = 0; wb = 0; wk = 0;
`ifdef FULL_SUB_STATS_EN
    exp_cnt = 0;
`endif
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".diff_q"},     diff_q,     exp_dq);
    check({tag, ".barrow_q"},   barrow_q,   exp_bq);
    check({tag, ".out_valid"},  out_valid,  exp_ov);
    check({tag, ".ser_diff"},   ser_diff,   exp_sd);
    check({tag, ".ser_borrow"}, ser_borrow, exp_sb);
    check({tag, ".ser_valid"},  ser_valid,  exp_sv);
`ifdef FULL_SUB_STATS_EN
    check({tag, ".borrow_cnt"}, borrow_cnt, exp_cnt);
`endif
  endtask

  // Called 1 unit after a rising edge with inputs already driven.
  task automatic cycle(input string tag);
    logic ed, eb;
    int   dd;
    #1;
    ref_sub(a, b, bin, ed, eb);
    check({tag, ".diff"},   diff,   ed);
    check({tag, ".barrow"}, barrow, eb);
    if (in_valid) begin
      exp_dq = ed;
      exp_bq = eb;
`ifdef FULL_SUB_STATS_EN
      if (eb && exp_cnt < CMAX) exp_cnt++;
`endif
    end
    exp_ov = in_valid;
    if (ser_en) begin
      if (ser_start) begin wa = 0; wb = 0; wk = 0; end
      wa = wa | (int'(ser_a) << wk);
      wb = wb | (int'(ser_b) << wk);
      wk++;
      dd = wa - wb;
      exp_sd = dd[wk-1];
      exp_sb = (wa < wb);
    end
    exp_sv = ser_en;
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic idle_inputs();
    a = 0; b = 0; bin = 0; in_valid = 0;
    ser_en = 0; ser_start = 0; ser_a = 0; ser_b = 0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 model_clear();
    check_regs("rst_async");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ser_word(input string tag, input logic [3:0] wa_in, input logic [3:0] wb_in,
                          output logic [3:0] res);
    for (int i = 0; i < 4; i++) begin
      ser_en = 1; ser_start = (i == 0); ser_a = wa_in[i]; ser_b = wb_in[i];
      cycle(tag);
      res[i] = ser_diff;
    end
    ser_en = 0; ser_start = 0;
  endtask

  logic [3:0] res;
  logic [2:0] v;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_clear();
    #12;
    check_regs("reset");

    // Exhaustive combinational truth table, applied while still in reset.
    for (int i = 0; i < 8; i++) begin
      logic ed, eb;
      v = 3'(i);
      {a, b, bin} = v;
      #10;
      ref_sub(v[2], v[1], v[0], ed, eb);
      check($sformatf("comb%0d.diff", i),   diff,   ed);
      check($sformatf("comb%0d.barrow", i), barrow, eb);
    end
    {a, b, bin} = 3'b001; #1;
    check("tt001", {diff, barrow}, 2'b11);
    {a, b, bin} = 3'b100; #1;
    check("tt100", {diff, barrow}, 2'b10);
    {a, b, bin} = 3'b111; #1;
    check("tt111", {diff, barrow}, 2'b11);
    check_regs("reset_hold");
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Registered path: capture then hold.
    a = 0; b = 1; bin = 1; in_valid = 1;
    cycle("reg1");
    check("reg1.spec", {diff_q, barrow_q, out_valid}, 3'b011);
    a = 1; b = 0; bin = 0; in_valid = 0;
    cycle("reg2");
    check("reg2.spec", {diff_q, barrow_q, out_valid}, 3'b010);

    // Serial 4-bit words.
    ser_word("ser_a", 4'b0101, 4'b0011, res);
    check("ser_a.res", res, 4'b0010);
    check("ser_a.brw", ser_borrow, 1'b0);
    ser_word("ser_b", 4'b0011, 4'b0101, res);
    check("ser_b.res", res, 4'b1110);
    check("ser_b.brw", ser_borrow, 1'b1);
    cycle("ser_idle");

    // Mid-word restart: brw is 1 here, the restart step must use borrow-in 0.
    ser_en = 1; ser_start = 0; ser_a = 0; ser_b = 1;
    cycle("restart_pre");
    ser_start = 1; ser_a = 1; ser_b = 0;
    cycle("restart");
    check("restart.spec", {ser_diff, ser_borrow}, 2'b10);

    // Async reset between edges with diff_q=1 and brw=1.
    a = 1; b = 0; bin = 0; in_valid = 1;
    ser_en = 1; ser_start = 1; ser_a = 0; ser_b = 1;
    cycle("pre_rst");
    check("pre_rst.spec", {diff_q, ser_borrow}, 2'b11);
    idle_inputs();
    #2 rst = 1'b1;
    #1 model_clear();
    check("async.diff_q", diff_q, 1'b0);
    check("async.brw", ser_borrow, 1'b0);
    a = 0; b = 1; bin = 0;
    #1 check("async.comb", {diff, barrow}, 2'b11);
    @(negedge clk) rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

`ifdef FULL_SUB_STATS_EN
    a = 0; b = 1; bin = 0; in_valid = 1;
    for (int i = 0; i < 7; i++) cycle("stats");
    check("stats.sat", borrow_cnt, 2'd3);
    idle_inputs();
`endif

    // Randomized mix of all paths, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        idle_inputs();
        pulse_reset();
      end
      a = 1'($urandom); b = 1'($urandom); bin = 1'($urandom);
      in_valid = 1'($urandom);
      ser_en = 1'($urandom);
      ser_start = ($urandom_range(0, 5) == 0) || (wk >= 24);
      ser_a = 1'($urandom); ser_b = 1'($urandom);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
